// File: rtl/ov7670_frame_capture_pkg.sv
// Shared definitions for the OV7670 frame capture block: FSM state encoding
// and the camera input synchronizer depth.
package ov7670_frame_capture_pkg;

  // Flops per camera input before the edge-detect stage.
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    VBLANK  = 3'd2,
    CAPTURE = 3'd3,
    CONV    = 3'd4,
    RELEASE = 3'd5,
    DONE    = 3'd6
  } cap_state_t;

endpackage

// File: rtl/ov7670_frame_capture_cam_sync_edge.sv
// Camera input conditioning: each input passes through SYNC_DEPTH synchronizer
// flops and then one registered edge-detect stage. The level, edge and data
// outputs all come out of that last stage, so they stay cycle-aligned.
module ov7670_frame_capture_cam_sync_edge
  import ov7670_frame_capture_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       pclk_rise,
  output logic       vsync,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href,
  output logic       href_fall,
  output logic [7:0] data
);

  localparam int TOP = SYNC_DEPTH - 1;

  logic [SYNC_DEPTH-1:0]      pclk_s, vsync_s, href_s;
  logic [SYNC_DEPTH-1:0][7:0] data_s;
  logic                       pclk_d;

  // Synchronizer shift chains for every camera input.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pclk_s  <= '0;
      vsync_s <= '0;
      href_s  <= '0;
      data_s  <= '0;
    end else begin
      pclk_s  <= {pclk_s[SYNC_DEPTH-2:0], cam_pclk};
      vsync_s <= {vsync_s[SYNC_DEPTH-2:0], cam_vsync};
      href_s  <= {href_s[SYNC_DEPTH-2:0], cam_href};
      data_s  <= {data_s[SYNC_DEPTH-2:0], cam_data};
    end
  end

  // Edge-detect stage: registered edges plus the matching delayed levels/data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pclk_d     <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= '0;
      pclk_rise  <= 1'b0;
      vsync_rise <= 1'b0;
      vsync_fall <= 1'b0;
      href_fall  <= 1'b0;
    end else begin
      pclk_d     <= pclk_s[TOP];
      vsync      <= vsync_s[TOP];
      href       <= href_s[TOP];
      data       <= data_s[TOP];
      pclk_rise  <= pclk_s[TOP] & ~pclk_d;
      vsync_rise <= vsync_s[TOP] & ~vsync;
      vsync_fall <= ~vsync_s[TOP] & vsync;
      href_fall  <= ~href_s[TOP] & href;
    end
  end

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 YUYV frame capture into byte-wide frame memory, followed by the
// conv_start / conv_end encoder handshake. Camera pins are oversampled in clk.
// Optional macro CAP_TEST_PATTERN_EN replaces written data with
// byte_cnt ^ line_cnt for bring-up without sensor content.
module ov7670_frame_capture
  import ov7670_frame_capture_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 200,
  parameter int WSZ    = $clog2(WIDTH),
  parameter int HSZ    = $clog2(HEIGHT),
  parameter int ASZ    = HSZ + WSZ
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           img_req,
  input  logic           cam_pclk,
  input  logic           cam_vsync,
  input  logic           cam_href,
  input  logic [7:0]     cam_data,
  output logic           mem_write_en,
  output logic [ASZ-1:0] mem_write_addr,
  output logic [7:0]     mem_write_data,
  output logic           conv_start,
  input  logic           conv_end,
  output logic           busy,
  output logic           frame_short
);

  localparam logic [WSZ:0]   LINE_END  = (WSZ+1)'(2 * WIDTH);
  localparam logic [ASZ-1:0] LINE_STEP = ASZ'(2 * WIDTH);
  localparam logic [HSZ:0]   LAST_LINE = (HSZ+1)'(HEIGHT - 1);

  cap_state_t     state, state_nxt;
  logic           req_q;
  logic [WSZ:0]   byte_cnt;
  logic [HSZ:0]   line_cnt;
  logic [ASZ-1:0] line_base;

  logic       pclk_rise, vsync, vsync_rise, vsync_fall, href, href_fall;
  logic [7:0] cam_byte;

  logic req_rise, last_fall, in_cap, wr;

  ov7670_frame_capture_cam_sync_edge u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .pclk_rise  (pclk_rise),
    .vsync      (vsync),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href       (href),
    .href_fall  (href_fall),
    .data       (cam_byte)
  );

  assign in_cap    = (state == CAPTURE);
  assign req_rise  = img_req & ~req_q;
  // Final line completing: takes priority over a coincident vsync rise.
  assign last_fall = href_fall & (line_cnt == LAST_LINE);
  // A write is dropped if the FSM leaves CAPTURE on this cycle, so the
  // registered strobe can never appear outside CAPTURE.
  assign wr = in_cap & pclk_rise & href & (byte_cnt < LINE_END) &
              ~last_fall & ~vsync_rise;

  // State register and img_req edge history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= img_req;
    end
  end

  // Next-state logic plus the state-decoded handshake outputs.
  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (req_rise) state_nxt = ARM;
      ARM:     if (vsync) state_nxt = VBLANK;
      VBLANK:  if (vsync_fall) state_nxt = CAPTURE;
      CAPTURE: if (last_fall || vsync_rise) state_nxt = CONV;
      CONV: begin
        conv_start = 1'b1;
        if (conv_end) state_nxt = RELEASE;
      end
      RELEASE: if (!conv_end) state_nxt = DONE;
      DONE:    if (!img_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, line base, registered write port and sticky short-frame flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byte_cnt       <= '0;
      line_cnt       <= '0;
      line_base      <= '0;
      mem_write_en   <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      frame_short    <= 1'b0;
    end else begin
      mem_write_en <= 1'b0;
      if (state == IDLE && req_rise)
        frame_short <= 1'b0;
      if (state == VBLANK && vsync_fall) begin
        byte_cnt  <= '0;
        line_cnt  <= '0;
        line_base <= '0;
      end
      if (wr) begin
        mem_write_en   <= 1'b1;
        mem_write_addr <= line_base + ASZ'(byte_cnt);
`ifdef CAP_TEST_PATTERN_EN
        mem_write_data <= 8'(byte_cnt) ^ 8'(line_cnt);
`else
        mem_write_data <= cam_byte;
`endif
        byte_cnt <= byte_cnt + (WSZ+1)'(1);
      end
      if (in_cap && href_fall) begin
        byte_cnt  <= '0;
        line_cnt  <= line_cnt + (HSZ+1)'(1);
        line_base <= line_base + LINE_STEP;
      end
      if (in_cap && vsync_rise && !last_fall)
        frame_short <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Randomized self-checking bench for ov7670_frame_capture (WIDTH=4, HEIGHT=2).
// Expected writes come from a per-frame reference list built from the
// capture rules: byte i of line l lands at l*2*WIDTH+i if i<2*WIDTH, l<HEIGHT.
module tb_ov7670_frame_capture;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  // Power-of-two WIDTH needs one extra column bit to hold the count 2*WIDTH.
  localparam int WSZ    = 3;
  localparam int ASZ    = 4;
  localparam int LB     = 2 * WIDTH;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           img_req = 1'b0;
  logic           cam_pclk = 1'b0;
  logic           cam_vsync = 1'b0;
  logic           cam_href = 1'b0;
  logic [7:0]     cam_data = 8'h00;
  logic           conv_end = 1'b0;
  logic           mem_write_en;
  logic [ASZ-1:0] mem_write_addr;
  logic [7:0]     mem_write_data;
  logic           conv_start;
  logic           busy;
  logic           frame_short;

  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;
  logic en_prev = 1'b0;

  int got_a[$];
  int got_d[$];
  int exp_a[$];
  int exp_d[$];

  ov7670_frame_capture #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .WSZ(WSZ), .ASZ(ASZ)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .img_req        (img_req),
    .cam_pclk       (cam_pclk),
    .cam_vsync      (cam_vsync),
    .cam_href       (cam_href),
    .cam_data       (cam_data),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .conv_start     (conv_start),
    .conv_end       (conv_end),
    .busy           (busy),
    .frame_short    (frame_short)
  );

  always #5 clk = ~clk;

  // Strobe collector; flags back-to-back strobes or strobes during conversion.
  always @(negedge clk) begin
    if (mem_write_en) begin
      got_a.push_back(int'(mem_write_addr));
      got_d.push_back(int'(mem_write_data));
      if (en_prev || conv_start) viol++;
    end
    en_prev = mem_write_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One camera byte: data set while pclk low, then a pclk rise held high.
  task automatic cam_byte_tx(input logic [7:0] d);
    cam_pclk = 1'b0;
    cam_data = d;
    tick(4);
    cam_pclk = 1'b1;
    tick(4);
  endtask

  task automatic clr_q();
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  // Arm, vsync pulse, nlines lines of nbytes; vsync rises early if short.
  task automatic capture(input int nlines, input int nbytes, input bit incr, input string tag);
    int k;
    int lat;
    logic [7:0] d;
    k = 0;
    lat = 0;
    clr_q();
    img_req = 1'b1;
    tick(2);
    chk({tag, "_fs_clr"}, frame_short, 0);
    chk({tag, "_busy"}, busy, 1);
    cam_vsync = 1'b1; tick(8);
    cam_vsync = 1'b0; tick(8);
    for (int l = 0; l < nlines; l++) begin
      cam_href = 1'b1;
      tick(2);
      for (int i = 0; i < nbytes; i++) begin
        d = incr ? 8'(k) : 8'($urandom);
        k++;
        if (i < LB && l < HEIGHT) begin
          exp_a.push_back(l * LB + i);
`ifdef CAP_TEST_PATTERN_EN
          exp_d.push_back((i ^ l) & 8'hff);
`else
          exp_d.push_back(int'(d));
`endif
        end
        cam_byte_tx(d);
      end
      tick(2);
      cam_href = 1'b0;
      cam_pclk = 1'b0;
      if (l != nlines - 1) tick(8);
    end
    if (nlines < HEIGHT) cam_vsync = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (conv_start) begin
        lat = c;
        break;
      end
    end
    // Three input stages to detect the edge, one more for the state change.
    chk({tag, "_conv_lat"}, lat, 4);
    chk({tag, "_fs"}, frame_short, (nlines < HEIGHT) ? 1 : 0);
    chk({tag, "_nwr"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got_a[i], exp_a[i]);
      chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
    end
  endtask

  // Encoder handshake through RELEASE and DONE back to IDLE.
  task automatic finish_conv(input string tag, input int hold);
    int drop;
    drop = 0;
    cam_vsync = 1'b0;
    for (int c = 0; c < hold; c++) begin
      tick(1);
      if (!conv_start) drop++;
    end
    chk({tag, "_hold"}, drop, 0);
    conv_end = 1'b1;
    tick(1);
    chk({tag, "_start_fall"}, conv_start, 0);
    chk({tag, "_busy_rel"}, busy, 1);
    conv_end = 1'b0;
    tick(1);
    chk({tag, "_busy_done"}, busy, 1);
    tick(3);
    chk({tag, "_no_rearm"}, busy, 1);
    img_req = 1'b0;
    tick(1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int nl;
    int nb;
    int n;
    tick(3);
    chk("rst_en", mem_write_en, 0);
    chk("rst_addr", mem_write_addr, 0);
    chk("rst_data", mem_write_data, 0);
    chk("rst_conv", conv_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fs", frame_short, 0);
    reset_n = 1'b1;
    tick(2);

    capture(2, 8, 1'b1, "full");
    finish_conv("full", 50);

    capture(2, 10, 1'b0, "long");
    finish_conv("long", 3);

    capture(1, 8, 1'b0, "short");
    finish_conv("short", 3);

    // Reset in the middle of a line after five writes.
    clr_q();
    img_req = 1'b1;
    tick(2);
    cam_vsync = 1'b1; tick(8);
    cam_vsync = 1'b0; tick(8);
    cam_href = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) cam_byte_tx(8'($urandom));
    tick(2);
    chk("mid_nwr", got_a.size(), 5);
    reset_n = 1'b0;
    img_req = 1'b0;
    tick(1);
    chk("mid_en", mem_write_en, 0);
    chk("mid_addr", mem_write_addr, 0);
    chk("mid_data", mem_write_data, 0);
    chk("mid_conv", conv_start, 0);
    chk("mid_busy", busy, 0);
    tick(2);
    reset_n = 1'b1;
    n = got_a.size();
    for (int i = 0; i < 3; i++) cam_byte_tx(8'($urandom));
    tick(4);
    cam_href = 1'b0;
    cam_pclk = 1'b0;
    tick(4);
    chk("post_rst_nowr", got_a.size(), n);
    chk("post_rst_busy", busy, 0);
    capture(2, 8, 1'b0, "restart");
    finish_conv("restart", 2);

    for (int r = 0; r < 4; r++) begin
      nl = $urandom_range(1, 2);
      nb = $urandom_range(5, 10);
      capture(nl, nb, 1'b0, $sformatf("rnd%0d", r));
      finish_conv($sformatf("rnd%0d", r), $urandom_range(1, 10));
    end

    chk("strobe_rules", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ov7670_frame_capture.md
Name: ov7670_frame_capture

Overview:
- Upstream stage of the JPEG encoder IP.
- Captures one OV7670 YUYV frame into the shared frame memory through a byte-wide write port.
- Then runs the encoder handshake: raises conv_start, waits for conv_end, drops conv_start.
- Camera signals are oversampled in the system clock domain. There is no second clock.

Parameters:
- WIDTH, 320: pixels per line; each line is 2*WIDTH bytes of YUYV.
- HEIGHT, 200: lines per frame.
- WSZ, $clog2(WIDTH): column width.
- HSZ, $clog2(HEIGHT): line-counter width.
- ASZ, HSZ+WSZ: memory address width. Design constraint: 2*WIDTH*HEIGHT <= 2**ASZ.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- img_req  in  1  level request from the host; its rising edge arms one capture.
- cam_pclk  in  1  camera pixel clock, asynchronous, sampled.
- cam_vsync  in  1  camera frame sync, active high during vertical blanking.
- cam_href  in  1  camera line valid.
- cam_data  in  8  camera byte.
- mem_write_en  out  1  one-cycle byte write strobe.
- mem_write_addr  out  ASZ  linear byte address.
- mem_write_data  out  8  byte to write.
- conv_start  out  1  encoder start, held level.
- conv_end  in  1  encoder finished; level.
- busy  out  1  high in every state except IDLE.
- frame_short  out  1  last frame ended before HEIGHT lines; sticky until the next arm.

Behaviour:
- Reset (synchronous, active-low):
  - All outputs are 0; state goes to IDLE.
  - All counters and synchronizers are cleared.
  - A reset mid-capture or mid-conversion drops conv_start in the same edge; no write strobe follows.
- Input sampling:
  - cam_pclk, cam_vsync, cam_href and cam_data pass through two synchronizer flops plus one edge-detect stage, all the same depth so they stay aligned.
  - A pclk rise is detected when the delayed sample is 0 and the current sample is 1.
  - Requires clk >= 4x pclk frequency, with pclk high and low phases each >= 2 clk.
- State machine:
  - IDLE: goes to ARM on an img_req rising edge (registered previous value). This clears frame_short.
  - ARM: waits for synchronized vsync = 1, then goes to VBLANK.
  - VBLANK: on the vsync falling edge, clears byte_cnt and line_cnt and goes to CAPTURE.
  - CAPTURE, on each pclk rise with href = 1 and byte_cnt < 2*WIDTH:
    - Writes cam_data at address line_cnt*2*WIDTH + byte_cnt.
    - Increments byte_cnt.
    - Bytes beyond 2*WIDTH in a line are dropped.
  - CAPTURE, on an href falling edge: line_cnt increments and byte_cnt clears.
  - CAPTURE exit, normal: when line_cnt reaches HEIGHT, go to CONV.
  - CAPTURE exit, early: a vsync rising edge before HEIGHT lines sets frame_short = 1 and goes to CONV. Partial lines are kept as written.
  - CONV: conv_start = 1; when conv_end = 1, go to RELEASE.
  - RELEASE: conv_start = 0; wait for conv_end = 0, then go to DONE.
  - DONE: goes to IDLE when img_req = 0. A request held high never re-arms.
- Write port timing:
  - mem_write_en, addr and data are registered. The strobe is one clk wide, issued the cycle after the pclk-rise detect, which is 4 clk after the raw pclk rise.
  - Never more than one strobe per pclk period.
  - mem_write_en is never asserted outside CAPTURE.
- Arithmetic:
  - byte_cnt is WSZ+1 bits; line_cnt is HSZ+1 bits.
  - The address is formed with an incrementing line-base register (base += 2*WIDTH on each href fall), so there is no multiplier.
  - Address width is truncated to ASZ.
- Simultaneous events:
  - An href fall and the HEIGHT-th line completion in the same cycle go to CONV, with frame_short = 0.
  - If a vsync rise coincides with the final href fall, the normal exit wins.
  - An img_req edge outside IDLE is ignored.

Optional Feature:
- Macro CAP_TEST_PATTERN_EN.
- Defined:
  - mem_write_data is replaced by (byte_cnt[7:0] ^ line_cnt[7:0]).
  - Timing, counters and handshake are unchanged.
  - Used for board bring-up without sensor image content.
- Undefined: mem_write_data is the synchronized cam_data. No pattern logic is synthesized.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE, ARM, VBLANK, CAPTURE, CONV, RELEASE, DONE;
  - the synchronizer depth constant (2).
- One natural sub-module, cam_sync_edge: a synchronizer plus edge detector for vsync, href and pclk, with the aligned data delay line.

Test Plan:
- Full frame, WIDTH=4, HEIGHT=2, cam_data incrementing from 0x00:
  - img_req 0->1, then a vsync pulse, then 2 lines of 8 bytes.
  - Expect 16 strobes, addr 0..15, data 0x00..0x0F.
  - conv_start rises one clk after the last line's href fall; frame_short = 0.
- Handshake:
  - Hold conv_end = 0 for 50 clk: conv_start stays 1.
  - Assert conv_end: conv_start falls next clk.
  - Drop conv_end: DONE; then img_req = 0 gives IDLE with busy = 0.
- Long line, 10 bytes per line with WIDTH=4:
  - Bytes 9-10 are not written.
  - The second line starts at addr 8.
- Short frame: vsync rises after 1 of 2 lines -> frame_short = 1, conv_start = 1, 8 writes total.
- Reset mid-CAPTURE after 5 writes:
  - The next clk shows all outputs 0 and no further strobes.
  - A new img_req edge restarts at addr 0.
- With CAP_TEST_PATTERN_EN defined, same stimulus as the full-frame test:
  - line 0 data 0x00..0x07;
  - line 1 data 0x01,0x00,0x03,0x02,0x05,0x04,0x07,0x06.
